// File: rtl/next_pc_predictor.sv
// Next-PC predictor: direct-mapped BTB with 2-bit counters
// and a saturating mispredict counter feeding PC_In.
module next_pc_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_if,
  input  logic        ex_update,
  input  logic [63:0] ex_pc,
  input  logic        ex_taken,
  input  logic [63:0] ex_target,
  input  logic        ex_mispredict,
  input  logic [63:0] ex_redirect_pc,
  output logic [63:0] pc_next,
  output logic        pred_taken,
  output logic [63:0] pred_target,
  output logic [31:0] mispredict_count
);

  localparam int TAG_W = 64 - 2 - IDX_W;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [63:0]      tgt_q   [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];

  logic [31:0] miss_cnt_q;
  logic [31:0] miss_cnt_d;

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic [1:0]       ex_ctr;
  logic [1:0]       ctr_d;

  logic [63:0] seq_pc;

  assign if_idx = pc_if[IDX_W+1:2];
  assign if_tag = pc_if[63:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[63:IDX_W+2];

  // Fetch-side lookup and next-PC selection
  always_comb begin
    if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = if_hit && ctr_q[if_idx][1];
    pred_target = tgt_q[if_idx];
    seq_pc      = pc_if + 64'd4;
    if (ex_mispredict) begin
      pc_next = ex_redirect_pc;
    end else if (pred_taken) begin
      pc_next = pred_target;
    end else begin
      pc_next = seq_pc;
    end
  end

  // Resolve-side hit test and saturating counter step
  always_comb begin
    ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    ex_ctr = ctr_q[ex_idx];
    ctr_d  = ex_ctr;
    if (ex_taken) begin
      if (ex_ctr != 2'b11) ctr_d = ex_ctr + 2'd1;
    end else begin
      if (ex_ctr != 2'b00) ctr_d = ex_ctr - 2'd1;
    end
  end

  // Table write: train on hit, allocate on taken miss
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (ex_update) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_d;
        if (ex_taken) tgt_q[ex_idx] <= ex_target;
      end else if (ex_taken) begin
        valid_q[ex_idx] <= 1'b1;
        tag_q[ex_idx]   <= ex_tag;
        tgt_q[ex_idx]   <= ex_target;
        ctr_q[ex_idx]   <= 2'b10;
      end
    end
  end

  // Saturating mispredict count next state
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (ex_mispredict && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  // Mispredict count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) miss_cnt_q <= '0;
    else       miss_cnt_q <= miss_cnt_d;
  end

  assign mispredict_count = miss_cnt_q;

endmodule

// File: doc/next_pc_predictor.md
NEXT_PC_PREDICTOR -- requirements
Module: next_pc_predictor

Interface
REQ-001 SHALL provide parameter ENTRIES, default 16, number of direct-mapped predictor entries (power of two, 4..64).
REQ-002 SHALL provide parameter IDX_W, default 4, index width equal to log2(ENTRIES).
REQ-003 SHALL provide the following ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high.
- pc_if  input  64  PC of the instruction currently in fetch.
- ex_update  input  1  resolved control-transfer instruction present in EX this cycle.
- ex_pc  input  64  PC of the resolved instruction.
- ex_taken  input  1  resolved direction: 1 = taken.
- ex_target  input  64  resolved taken target.
- ex_mispredict  input  1  fetch path was wrong; redirect required.
- ex_redirect_pc  input  64  correct next PC when ex_mispredict = 1.
- pc_next  output  64  value presented to the program counter's PC_In.
- pred_taken  output  1  fetch predicted taken this cycle.
- pred_target  output  64  predicted target (valid only when pred_taken = 1).
- mispredict_count  output  32  saturating count of ex_mispredict cycles.

Function
REQ-004 SHALL hold per entry: valid (1b), tag (64-2-IDX_W bits), target (64b), 2-bit saturating counter.
REQ-005 SHALL form index = pc[IDX_W+1:2] and tag = pc[63:IDX_W+2]; pc[1:0] is ignored.
REQ-006 SHALL perform lookup combinationally on pc_if: hit = valid[idx] && tag[idx] == tag(pc_if).
REQ-007 SHALL drive pred_taken = hit && counter[idx][1], and pred_target = target[idx].
REQ-008 SHALL select pc_next by priority: ex_mispredict -> ex_redirect_pc; else pred_taken -> pred_target; else pc_if + 4.
REQ-009 SHALL compute pc_if + 4 modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC -> 0x0).
REQ-010 SHALL, on ex_update with a hit for ex_pc:
- taken: increment counter, saturating at 2'b11, and write target <= ex_target;
- not taken: decrement counter, saturating at 2'b00; target unchanged.
REQ-011 SHALL, on ex_update with a miss and ex_taken = 1, allocate the indexed entry (overwriting any occupant): valid=1, tag, target = ex_target, counter = 2'b10.
REQ-012 SHALL, on ex_update with a miss and ex_taken = 0, leave the table unchanged.
REQ-013 SHALL make table updates visible to lookup from the next cycle; a same-cycle lookup of the entry being updated returns the pre-update contents (no bypass).
REQ-014 SHALL ignore ex_taken, ex_target and ex_pc when ex_update = 0; ex_mispredict acts independently of ex_update.
REQ-015 SHALL increment mispredict_count on each cycle with ex_mispredict = 1, saturating at 0xFFFF_FFFF.
REQ-016 SHALL contain no stall input; stalling is performed by the program counter, and pc_next remains a pure function of current inputs and state.

Reset
REQ-017 SHALL, on reset assertion, immediately clear all valid bits, set all counters to 2'b01, zero all targets and tags, and zero mispredict_count.
REQ-018 SHALL, with reset asserted, drive pc_next as in REQ-008 using the cleared table (pred_taken = 0); reset asserted mid-update discards that update.
REQ-019 SHALL resume updates on the first rising clk edge after reset deasserts.

Verification
REQ-020 Reset, pc_if=0x1000 -> pc_next=0x1004, pred_taken=0, mispredict_count=0.
REQ-021 ex_update=1, ex_pc=0x1000, ex_taken=1, ex_target=0x2000 for one cycle; next cycle pc_if=0x1000 -> pred_taken=1, pc_next=0x2000.
REQ-022 From REQ-021 state, apply two not-taken updates for 0x1000 -> counter 10->01->00; pc_if=0x1000 -> pc_next=0x1004; a further not-taken update keeps the counter at 00.
REQ-023 Aliasing: entry holds 0x1000; taken update for 0x1040 (same index, ENTRIES=16) -> pc_if=0x1000 misses (pc_next=0x1004); pc_if=0x1040 hits.
REQ-024 Same-cycle priority: pred_taken=1 and ex_mispredict=1 with ex_redirect_pc=0x3000 -> pc_next=0x3000; mispredict_count increments by 1.
REQ-025 Wrap/saturation: pc_if=0xFFFF_FFFF_FFFF_FFFC, table empty -> pc_next=0x0; force mispredict_count to 0xFFFF_FFFF -> it stays at 0xFFFF_FFFF after a further mispredict.
